// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, register-load, ALU drive/return and result signals of alu_issue_ctrl
interface alu_issue_ctrl_if #(parameter int W = 32, parameter int AW = 3);
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs;
  logic [AW-1:0] instr_rt;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_r2;
  logic [W-1:0]  alu_r3;
  logic [W-1:0]  alu_r0;
  logic          alu_overflow;
  logic          alu_zero;
  logic          alu_carry;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [2:0]    res_flags;
  logic          sticky_ovf;
  logic          sticky_clr;
  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
    input  ld_en, ld_addr, ld_data,
    input  alu_r0, alu_overflow, alu_zero, alu_carry,
    input  res_ready, sticky_clr,
    output instr_ready, alu_op, alu_r2, alu_r3,
    output res_valid, res_data, res_flags, sticky_ovf
  );
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
    output ld_en, ld_addr, ld_data,
    output alu_r0, alu_overflow, alu_zero, alu_carry,
    output res_ready, sticky_clr,
    input  instr_ready, alu_op, alu_r2, alu_r3,
    input  res_valid, res_data, res_flags, sticky_ovf
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file instructions to an external combinational ALU and returns R0/flags.
// Optional sticky overflow accumulator enabled by ALU_CTRL_STICKY_OVF_EN.
module alu_issue_ctrl #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_ctrl_if.slave  bus
);
  localparam int NREG = 1 << AW;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  r2_q, r2_d, r3_q, r3_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [W-1:0]  data_q, data_d;
  logic [2:0]    flags_q, flags_d;
  logic          sticky_q, sticky_d;
  logic [W-1:0]  rf_q [NREG];
  logic [W-1:0]  rf_d [NREG];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    rd_d    = rd_q;
    data_d  = data_q;
    flags_d = flags_q;
    rf_d    = rf_q;
    if (bus.ld_en) rf_d[bus.ld_addr] = bus.ld_data;
    // operands come from rf_q so a same-edge load is not seen; writeback follows the load so it wins
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        op_d    = bus.instr_op;
        r2_d    = rf_q[bus.instr_rs];
        r3_d    = rf_q[bus.instr_rt];
        rd_d    = bus.instr_rd;
        state_d = ISSUE;
      end
      ISSUE: begin
        data_d      = bus.alu_r0;
        flags_d     = {bus.alu_overflow, bus.alu_zero, bus.alu_carry};
        rf_d[rd_q]  = bus.alu_r0;
        state_d     = RESP;
      end
      RESP: state_d = bus.res_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
`ifdef ALU_CTRL_STICKY_OVF_EN
  always_comb sticky_d = (state_q == ISSUE && bus.alu_overflow) ? 1'b1 : bus.sticky_clr ? 1'b0 : sticky_q;
`else
  logic unused_clr;
  assign unused_clr = bus.sticky_clr;
  always_comb sticky_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      flags_q  <= '0;
      sticky_q <= 1'b0;
      rf_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      rf_q     <= rf_d;
    end
  end
  assign bus.instr_ready = state_q == IDLE;
  assign bus.res_valid   = state_q == RESP;
  assign bus.alu_op      = op_q;
  assign bus.alu_r2      = r2_q;
  assign bus.alu_r3      = r3_q;
  assign bus.res_data    = data_q;
  assign bus.res_flags   = flags_q;
  assign bus.sticky_ovf  = sticky_q;
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue controller that drives the team's combinational `ALU` (opcode/R2/R3 in, R0/overflow/zero/carry out) from the other side. It accepts three-register instructions over a valid/ready handshake and reads operands from an internal register file. It presents opcode and operands to the ALU, captures R0 and the flags, writes R0 back, and returns the result and flags over a second valid/ready handshake. It sits between the instruction source and the ALU instance, which is external to this block.

## Interface
- `W`, 32: datapath width; must match the ALU `W`.
- `AW`, 3: register address width; register file depth NREG = 2^AW.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `instr_valid` input 1: instruction offered.
- `instr_ready` output 1: controller can accept an instruction; high only in IDLE.
- `instr_op` input 3: ALU opcode. 000 MOV, 001 NOT, 010 ADD, 011 NOR, 100 SUB, 101 NAND, 110 AND, 111 SLT.
- `instr_rd`, `instr_rs`, `instr_rt` input AW each: destination, R2 source, R3 source.
- `ld_en` input 1, `ld_addr` input AW, `ld_data` input W: direct register-file write port.
- `alu_op` output 3, `alu_r2` output W, `alu_r3` output W: registered drive to the ALU.
- `alu_r0` input W, `alu_overflow` input 1, `alu_zero` input 1, `alu_carry` input 1: ALU results.
- `res_valid` output 1, `res_ready` input 1: result handshake.
- `res_data` output W: captured R0.
- `res_flags` output 3: captured {overflow, zero, carry}.
- `sticky_ovf` output 1, `sticky_clr` input 1: accumulated overflow (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: `instr_ready`=1. On `instr_valid`&`instr_ready`:
  - latch `alu_op`, `alu_r2`=reg[rs], `alu_r3`=reg[rt] and rd;
  - go to ISSUE.
- ISSUE: at the edge ending ISSUE:
  - sample `alu_r0` into `res_data` and {`alu_overflow`,`alu_zero`,`alu_carry`} into `res_flags`;
  - write `alu_r0` into reg[rd];
  - go to RESP.
- RESP: `res_valid`=1. `res_data`/`res_flags` are held stable until `res_valid`&`res_ready`, then the FSM returns to IDLE.
- `alu_op`, `alu_r2` and `alu_r3` hold their values until the next acceptance.
- The block does not recompute flags; they are the ALU's values verbatim. SLT writes 0 or 1 zero-extended to W.
- The register file is NREG×W flops, read combinationally at acceptance. rs=rt and rd=rs are legal.
- `ld_en` is honoured in every state.
- Same-edge `ld_en` write and writeback to the same register: writeback wins.
- Same-edge `ld_en` write and acceptance reading that register: the old value is read.
- Instructions offered outside IDLE are ignored; `instr_ready`=0 stalls the source.

## Timing
- Acceptance edge E. `alu_*` valid from E+1. Writeback and capture at E+2. `res_valid` high from E+2.
- Minimum initiation interval is 3 cycles when `res_ready` is held high.
- The ALU is combinational, so its path must close within one cycle from the `alu_*` flops.
- Reset (`rst_n`=0 at an edge):
  - state IDLE, `instr_ready`=1;
  - `res_valid`=0, `res_data`=0, `res_flags`=0;
  - `alu_op`=0, `alu_r2`=0, `alu_r3`=0;
  - all registers 0, `sticky_ovf`=0.
- Reset in ISSUE or RESP aborts the instruction with no writeback and no result.

## Configuration
- `ALU_CTRL_STICKY_OVF_EN` defined:
  - `sticky_ovf` is set at any capture edge where `alu_overflow`=1;
  - it is cleared by `sticky_clr`=1 at an edge;
  - set wins over clear on the same edge.
- Not defined: `sticky_ovf` is constant 0 and `sticky_clr` is ignored.

## Test plan
- Load r1=5, r2=7; issue ADD rd=3 → `res_data`=12, `res_flags`=000, r3=12; `res_valid` at E+2.
- Load r1=0x7FFFFFFF, r2=0xFFFFFFFF; issue SUB → `res_data`=0x80000000, `res_flags`=100; `sticky_ovf`=1 only with the macro defined.
- Load r4=5; issue SUB rs=rt=4 → `res_data`=0, `res_flags`=011; then SLT with r1=0xFFFFFFFF, r2=1 → `res_data`=1.
- Hold `res_ready`=0 for 4 cycles in RESP → `res_data`/`res_flags` stable, `instr_ready`=0, offered instructions not taken; release → IDLE next cycle.
- Writeback to r3 and `ld_en` to r3 (0xDEAD) on the same edge → r3 holds the ALU result.
- `rst_n`=0 during ISSUE → no writeback to rd, `res_valid` stays 0, all outputs at reset values.
